wb_slave_decoder: RTL and testbench

Bus-side controller that follows the master arbiter: routes the single granted Wishbone master port to one of `SLAVES_COUNT` slaves by decoding upper address bits, and protects the bus with a per-transfer timeout watchdog. A slave that never acknowledges has its cycle terminated with a one-cycle error to the master. The block also records the address and count of timed-out transfers.

---
 rtl/wb_slave_decoder.sv | 128 ++++++++++++
 tb/tb_wb_slave_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_decoder.sv
// Wishbone slave-side decoder: routes the granted master to one slave chosen by
// the upper address bits, and terminates unanswered strobes with a one-cycle error.
module wb_slave_decoder #(
  parameter int SLAVES_WIDTH   = 2,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        mCycI,
  input  logic                                        mStbI,
  input  logic                                        mWeI,
  input  logic [ADDRESS_WIDTH-1:0]                    mAdrI,
  input  logic [DATA_WIDTH-1:0]                       mDatI,
  output logic                                        mAckO,
  output logic                                        mErrO,
  output logic [DATA_WIDTH-1:0]                       mDatO,
  output logic [(1<<SLAVES_WIDTH)-1:0]                sCycO,
  output logic [(1<<SLAVES_WIDTH)-1:0]                sStbO,
  output logic                                        sWeO,
  output logic [ADDRESS_WIDTH-1:0]                    sAdrO,
  output logic [DATA_WIDTH-1:0]                       sDatO,
  input  logic [(1<<SLAVES_WIDTH)-1:0]                sAckI,
  input  logic [DATA_WIDTH*(1<<SLAVES_WIDTH)-1:0]     sDatIPacked,
  output logic [7:0]                                  errCount,
  output logic [ADDRESS_WIDTH-1:0]                    errAdr
);

  localparam int SLAVES_COUNT = 1 << SLAVES_WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]               state_q, state_d;
  logic [SLAVES_WIDTH-1:0]  sel_q, sel_d;
  logic [7:0]               timer_q, timer_d;
  logic [7:0]               err_count_q, err_count_d;
  logic [ADDRESS_WIDTH-1:0] err_adr_q, err_adr_d;

  logic sel_ack;
  logic stalled;

  assign sel_ack = sAckI[sel_q];
  assign stalled = mStbI & ~sel_ack;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d     = state_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    err_count_d = err_count_q;
    err_adr_d   = err_adr_q;

    case (state_q)
      IDLE: begin
        if (mCycI & mStbI) begin
          sel_d   = mAdrI[ADDRESS_WIDTH-1 -: SLAVES_WIDTH];
          timer_d = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // Cycle drop takes priority over a timeout expiring in the same cycle.
        if (!mCycI) begin
          state_d = IDLE;
        end else if (stalled && timer_q == TIMER_LAST) begin
          state_d     = ERROR;
          err_adr_d   = mAdrI;
          err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
        end else if (stalled) begin
          timer_d = timer_q + 8'd1;
        end else begin
          timer_d = '0;
        end
      end
      ERROR:   state_d = mCycI ? DRAIN : IDLE;
      DRAIN:   if (!mCycI) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      timer_q     <= '0;
      err_count_q <= '0;
      err_adr_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      err_count_q <= err_count_d;
      err_adr_q   <= err_adr_d;
    end
  end

  // Slave handshakes are decoded from the registered state, so reset drops them at once.
  always_comb begin
    sCycO = '0;
    sStbO = '0;
    mAckO = 1'b0;
    mErrO = 1'b0;
    case (state_q)
      ACTIVE: begin
        sCycO[sel_q] = mCycI;
        sStbO[sel_q] = mStbI;
        mAckO        = sel_ack & mStbI;
      end
      ERROR:   mErrO = 1'b1;
      default: ;
    endcase
  end

  assign mDatO    = sDatIPacked[DATA_WIDTH*sel_q +: DATA_WIDTH];
  assign sWeO     = mWeI;
  assign sAdrO    = mAdrI;
  assign sDatO    = mDatI;
  assign errCount = err_count_q;
  assign errAdr   = err_adr_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Self-checking bench for wb_slave_decoder: directed scenarios plus random transfers
// compared against a transaction-level outcome model.
module tb_wb_slave_decoder;

  localparam int SW = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 4;
  localparam int NS = 1 << SW;

  logic              clk = 1'b0;
  logic              rst;
  logic              mCycI, mStbI, mWeI;
  logic [AW-1:0]     mAdrI;
  logic [DW-1:0]     mDatI;
  logic              mAckO, mErrO;
  logic [DW-1:0]     mDatO;
  logic [NS-1:0]     sCycO, sStbO;
  logic              sWeO;
  logic [AW-1:0]     sAdrO;
  logic [DW-1:0]     sDatO;
  logic [NS-1:0]     sAckI;
  logic [DW*NS-1:0]  sDatIPacked;
  logic [7:0]        errCount;
  logic [AW-1:0]     errAdr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: error statistics only change on a transfer that times out.
  int            m_err_cnt = 0;
  logic [AW-1:0] m_err_adr = '0;

  wb_slave_decoder #(
    .SLAVES_WIDTH(SW), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .mCycI(mCycI), .mStbI(mStbI), .mWeI(mWeI), .mAdrI(mAdrI), .mDatI(mDatI),
    .mAckO(mAckO), .mErrO(mErrO), .mDatO(mDatO),
    .sCycO(sCycO), .sStbO(sStbO), .sWeO(sWeO), .sAdrO(sAdrO), .sDatO(sDatO),
    .sAckI(sAckI), .sDatIPacked(sDatIPacked),
    .errCount(errCount), .errAdr(errAdr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One master transfer with a bench slave that acks on strobe cycle ack_at (0 = never).
  task automatic run_xfer(input logic [AW-1:0] addr, input logic we, input int ack_at,
                          input logic [DW-1:0] tgt_dat,
                          output int n_stb, output int n_ack, output int n_err,
                          output int first_stb, output logic stray,
                          output logic [DW-1:0] dat_at_ack);
    int            target;
    logic [NS-1:0] tmask;
    logic          ack_seen, err_seen;
    target   = int'(addr[AW-1 -: SW]);
    tmask    = '0;
    tmask[target] = 1'b1;
    n_stb = 0; n_ack = 0; n_err = 0; first_stb = -1; stray = 1'b0; dat_at_ack = '0;
    ack_seen = 1'b0; err_seen = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NS; k++) sDatIPacked[DW*k +: DW] = $urandom;
    sDatIPacked[DW*target +: DW] = tgt_dat;
    mCycI = 1'b1; mStbI = 1'b1; mWeI = we; mAdrI = addr; mDatI = $urandom; sAckI = '0;
    for (int c = 0; c < T + 6; c++) begin
      #2;
      if (((sStbO | sCycO) & ~tmask) != '0) stray = 1'b1;
      if (sAdrO !== mAdrI || sWeO !== mWeI || sDatO !== mDatI) stray = 1'b1;
      if (sStbO[target]) begin
        n_stb++;
        if (first_stb < 0) first_stb = c;
      end
      sAckI = '0;
      if (sStbO[target] && n_stb == ack_at) sAckI[target] = 1'b1;
      #1;
      if (mAckO) begin n_ack++; dat_at_ack = mDatO; ack_seen = 1'b1; end
      if (mErrO) begin n_err++; err_seen = 1'b1; end
      if (err_seen && (sStbO | sCycO) != '0) stray = 1'b1;
      @(posedge clk); #1;
      if (ack_seen) begin mCycI = 1'b0; mStbI = 1'b0; end
      else if (err_seen) mStbI = 1'b0;
    end
    mCycI = 1'b0; mStbI = 1'b0; sAckI = '0;
  endtask

  task automatic xfer_and_check(input string tag, input logic [AW-1:0] addr, input int ack_at,
                                input logic [DW-1:0] tgt_dat);
    int            n_stb, n_ack, n_err, first_stb;
    logic          stray;
    logic [DW-1:0] dat;
    bit            exp_ack;
    run_xfer(addr, 1'($urandom), ack_at, tgt_dat, n_stb, n_ack, n_err, first_stb, stray, dat);
    exp_ack = (ack_at >= 1 && ack_at <= T);
    if (!exp_ack) begin
      m_err_cnt = (m_err_cnt >= 255) ? 255 : m_err_cnt + 1;
      m_err_adr = addr;
    end
    check({tag, ".strobes"},   64'(n_stb), exp_ack ? 64'(ack_at) : 64'(T));
    check({tag, ".acks"},      64'(n_ack), 64'(exp_ack));
    check({tag, ".errs"},      64'(n_err), 64'(!exp_ack));
    check({tag, ".first_stb"}, 64'(first_stb), 64'd1);
    check({tag, ".stray"},     64'(stray), 64'd0);
    if (exp_ack) check({tag, ".data"}, 64'(dat), 64'(tgt_dat));
    check({tag, ".errCount"},  64'(errCount), 64'(m_err_cnt));
    check({tag, ".errAdr"},    64'(errAdr), 64'(m_err_adr));
  endtask

  initial begin
    int            s0, s3, acks;
    logic          addr_moved;
    int            errs_seen;
    logic [AW-1:0] ra;

    rst = 1'b1; mCycI = 1'b0; mStbI = 1'b0; mWeI = 1'b0; mAdrI = '0; mDatI = '0;
    sAckI = '0; sDatIPacked = '0;
    #12;
    check("reset.sCycO", 64'(sCycO), 64'd0);
    check("reset.sStbO", 64'(sStbO), 64'd0);
    check("reset.mAckO", 64'(mAckO), 64'd0);
    check("reset.mErrO", 64'(mErrO), 64'd0);
    check("reset.errCount", 64'(errCount), 64'd0);
    check("reset.errAdr", 64'(errAdr), 64'd0);
    #10 rst = 1'b0;

    xfer_and_check("routing",  32'h8000_0010, 2, 32'hCAFE_F00D);
    xfer_and_check("timeout",  32'h4000_0000, 0, 32'h1234_5678);
    xfer_and_check("boundary", 32'h4000_0040, T, 32'h0BAD_BEEF);
    xfer_and_check("after_to", 32'hC000_0004, 1, 32'h5555_AAAA);

    // Sticky select: the second strobe of one cycle addresses slave 3 but stays on slave 0.
    s0 = 0; s3 = 0; acks = 0; addr_moved = 1'b0;
    @(posedge clk); #1;
    mCycI = 1'b1; mStbI = 1'b1; mAdrI = 32'h0000_0100;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (sStbO[3]) s3++;
      if (sStbO[0]) s0++;
      sAckI = '0;
      sAckI[0] = sStbO[0];
      #1;
      if (mAckO) acks++;
      @(posedge clk); #1;
      if (acks == 1 && !addr_moved) begin mAdrI = 32'hC000_0000; addr_moved = 1'b1; end
      if (acks >= 2) begin mCycI = 1'b0; mStbI = 1'b0; end
    end
    mCycI = 1'b0; mStbI = 1'b0; sAckI = '0;
    check("sticky.s0_strobes", 64'(s0), 64'd2);
    check("sticky.s3_strobes", 64'(s3), 64'd0);
    check("sticky.acks", 64'(acks), 64'd2);

    // Cycle dropped in the cycle that would otherwise time out: no error.
    @(posedge clk); #1;
    mCycI = 1'b1; mStbI = 1'b1; mAdrI = 32'h4000_0200; sAckI = '0;
    repeat (T) @(posedge clk);
    #1 mCycI = 1'b0;
    errs_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (mErrO) errs_seen++;
    end
    mStbI = 1'b0;
    check("drop_vs_timeout.errs", 64'(errs_seen), 64'd0);
    check("drop_vs_timeout.errCount", 64'(errCount), 64'(m_err_cnt));

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      xfer_and_check("random", ra, int'($urandom_range(0, T + 2)), $urandom);
    end

    for (int i = 0; i < 260; i++) begin
      ra = $urandom;
      xfer_and_check("saturate", ra, 0, $urandom);
    end
    check("saturate.final", 64'(errCount), 64'd255);

    // Asynchronous reset in the middle of an active strobe.
    @(posedge clk); #1;
    mCycI = 1'b1; mStbI = 1'b1; mAdrI = 32'h8000_0000; sAckI = '0;
    @(posedge clk); #3;
    check("areset.pre_stb2", 64'(sStbO[2]), 64'd1);
    rst = 1'b1;
    #1;
    check("areset.sCycO", 64'(sCycO), 64'd0);
    check("areset.sStbO", 64'(sStbO), 64'd0);
    check("areset.mErrO", 64'(mErrO), 64'd0);
    mCycI = 1'b0; mStbI = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    m_err_cnt = 0; m_err_adr = '0;
    check("areset.errCount", 64'(errCount), 64'd0);
    check("areset.errAdr", 64'(errAdr), 64'd0);
    xfer_and_check("post_reset", 32'h8000_0020, 1, 32'hFEED_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
